usrt_tx_sched: RTL and testbench

- Transmit scheduler/controller for the USRT transmit path.
- Arbitrates round-robin between two byte requesters and latches the winning byte together with its parity configuration.
- Sequences the frame onto the serial line LSB-first, one bit per i_BitEn strobe: start bit, 8 data bits, optional parity bit, stop bit(s).
- Sits between the host-side byte sources and the USRT line driver.

---
 rtl/usrt_tx_sched.sv | 139 +++++++++++++
 tb/tb_usrt_tx_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx_sched.sv
// Transmit scheduler: round-robin grant between two byte sources, then LSB-first serial framing.
// Latency: o_Gnt one cycle after a request seen in IDLE; start bit on the first i_BitEn after the grant.
// Backpressure: requesters hold i_Req until o_Gnt; one frame in flight, new requests wait until IDLE.
module usrt_tx_sched #(
   parameter int STOP_BITS = 1
) (
   input  logic       i_Pclk,
   input  logic       i_Rst,
   input  logic       i_BitEn,
   input  logic [1:0] i_Parity,
   input  logic [1:0] i_Req,
   input  logic [7:0] i_Data0,
   input  logic [7:0] i_Data1,
   output logic [1:0] o_Gnt,
   output logic       o_Tx,
   output logic       o_Busy,
   output logic       o_FrameDone
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // Stop counter only ever needs to reach 1 (two stop bits at most).
   localparam logic SC_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   state_t     state;
   logic [7:0] d;
   logic [2:0] cnt;
   logic       sc;
   logic       par_en;
   logic       p;
   logic       rr_ptr;
   logic       win;
   logic [7:0] win_dat;

   // Winner select: a lone requester wins outright; on a tie the pointer names the favoured one.
   always_comb begin
      win = 1'b0;
      if (i_Req == 2'b10) begin
         win = 1'b1;
      end else if (i_Req == 2'b11) begin
         win = rr_ptr;
      end
      win_dat = win ? i_Data1 : i_Data0;
   end

   // Frame sequencer: grant/latch in IDLE, then advance one bit per i_BitEn with o_Tx registered.
   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         d           <= 8'h00;
         cnt         <= 3'd0;
         sc          <= 1'b0;
         par_en      <= 1'b0;
         p           <= 1'b0;
         rr_ptr      <= 1'b0;
         o_Gnt       <= 2'b00;
         o_Tx        <= 1'b1;
         o_Busy      <= 1'b0;
         o_FrameDone <= 1'b0;
      end else begin
         o_Gnt       <= 2'b00;
         o_FrameDone <= 1'b0;
         case (state)
            ST_IDLE: begin
               // i_BitEn is deliberately ignored here so WAIT always needs a fresh strobe.
               if (i_Req != 2'b00) begin
                  d      <= win_dat;
                  par_en <= (i_Parity == 2'b01) || (i_Parity == 2'b10);
                  p      <= (i_Parity == 2'b10) ? ~^win_dat : ^win_dat;
                  o_Gnt  <= win ? 2'b10 : 2'b01;
                  rr_ptr <= ~win;
                  state  <= ST_WAIT;
                  o_Busy <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (i_BitEn) begin
                  state <= ST_START;
                  o_Tx  <= 1'b0;
               end
            end
            ST_START: begin
               if (i_BitEn) begin
                  state <= ST_DATA;
                  cnt   <= 3'd0;
                  o_Tx  <= d[0];
               end
            end
            ST_DATA: begin
               if (i_BitEn) begin
                  if (cnt != 3'd7) begin
                     cnt  <= cnt + 3'd1;
                     o_Tx <= d[cnt + 3'd1];
                  end else if (par_en) begin
                     state <= ST_PARITY;
                     o_Tx  <= p;
                  end else begin
                     state <= ST_STOP;
                     sc    <= 1'b0;
                     o_Tx  <= 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (i_BitEn) begin
                  state <= ST_STOP;
                  sc    <= 1'b0;
                  o_Tx  <= 1'b1;
               end
            end
            ST_STOP: begin
               if (i_BitEn) begin
                  if (sc != SC_LAST) begin
                     sc <= sc + 1'b1;
                  end else begin
                     state       <= ST_IDLE;
                     o_Busy      <= 1'b0;
                     o_FrameDone <= 1'b1;
                     o_Tx        <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               o_Busy <= 1'b0;
               o_Tx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Bench for usrt_tx_sched: one instance with one stop bit, one with two, separate inputs each.
// Frames are driven from a vector table plus hand sequences for arbitration and mid-frame reset.
// Expected grants and line bits are queued at stimulus time and consumed by a negedge monitor.
module tb_usrt_tx_sched;

   typedef struct {
      int         inst;
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] par;
      logic [1:0] gnt;
      int         len;
      bit         chg;
      bit         irr;
      bit         sync;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_en = 1'b0;
   logic       irr = 1'b0;
   logic       be_last = 1'b0;
   logic [1:0] req_a [2];
   logic [7:0] d0_a [2];
   logic [7:0] d1_a [2];
   logic [1:0] par_a [2];
   logic [1:0] gnt_w [2];
   logic       tx_w [2];
   logic       busy_w [2];
   logic       done_w [2];

   int nvec = 0;
   int nerr = 0;

   // Scoreboard rings: bit values 0/1, value 2 marks the frame-done edge.
   int         eb [2][64];
   int         ehd [2] = '{0, 0};
   int         etl [2] = '{0, 0};
   logic [1:0] eg [2][8];
   int         ghd [2] = '{0, 0};
   int         gtl [2] = '{0, 0};
   bit         act [2] = '{0, 0};
   logic       last_tx [2];

   always #5 clk = ~clk;

   usrt_tx_sched #(.STOP_BITS(1)) u_dut1 (
      .i_Pclk(clk), .i_Rst(rst), .i_BitEn(bit_en), .i_Parity(par_a[0]), .i_Req(req_a[0]),
      .i_Data0(d0_a[0]), .i_Data1(d1_a[0]), .o_Gnt(gnt_w[0]), .o_Tx(tx_w[0]),
      .o_Busy(busy_w[0]), .o_FrameDone(done_w[0])
   );

   usrt_tx_sched #(.STOP_BITS(2)) u_dut2 (
      .i_Pclk(clk), .i_Rst(rst), .i_BitEn(bit_en), .i_Parity(par_a[1]), .i_Req(req_a[1]),
      .i_Data0(d0_a[1]), .i_Data1(d1_a[1]), .o_Gnt(gnt_w[1]), .o_Tx(tx_w[1]),
      .o_Busy(busy_w[1]), .o_FrameDone(done_w[1])
   );

   task automatic chk(input string nm, input int i, input int a, input int e);
      nvec++;
      if (a != e) begin
         nerr++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, i, a, e, $time);
      end
   endtask

   task automatic fail_now(input string nm, input int i);
      nvec++;
      nerr++;
      $display("FAIL %s[%0d]: expected event did not occur at %0t", nm, i, $time);
   endtask

   task automatic push_bit(input int i, input int v);
      eb[i][etl[i] % 64] = v;
      etl[i]++;
   endtask

   task automatic push_gnt(input int i, input logic [1:0] g);
      eg[i][gtl[i] % 8] = g;
      gtl[i]++;
   endtask

   // Reference frame: start, LSB-first data, optional parity, STOP_BITS (= inst+1) stops, done.
   task automatic push_frame(input int i, input logic [7:0] d, input logic [1:0] par);
      push_bit(i, 0);
      for (int k = 0; k < 8; k++) push_bit(i, int'(d[k]));
      if (par == 2'b01) push_bit(i, int'(^d));
      else if (par == 2'b10) push_bit(i, int'(~^d));
      for (int k = 0; k < i + 1; k++) push_bit(i, 1);
      push_bit(i, 2);
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 2; i++) begin
         ehd[i] = etl[i];
         ghd[i] = gtl[i];
         act[i] = 1'b0;
      end
   endtask

   task automatic wait_gnt(input int i, output bit got);
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (gnt_w[i] != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now("gnt_timeout", i);
   endtask

   task automatic wait_done(input int i);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done_w[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now("done_timeout", i);
   endtask

   // Bit strobe: every 4 cycles, or gaps cycling 1,3,7 in irregular mode.
   initial begin
      int k;
      int gap;
      k = 0;
      forever begin
         if (irr) gap = (k == 0) ? 1 : (k == 1) ? 3 : 7;
         else gap = 4;
         for (int c = 0; c < gap - 1; c++) begin
            @(posedge clk);
            #1 bit_en = 1'b0;
         end
         @(posedge clk);
         #1 bit_en = 1'b1;
         k = (k + 1) % 3;
      end
   end

   always @(posedge clk) be_last <= bit_en;

   // Monitor: grants, bit values on strobe edges, hold between strobes, idle line otherwise.
   always @(negedge clk) begin
      int e;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (gnt_w[i] != 2'b00) begin
               chk("gnt_overlap", i, int'(act[i]), 0);
               if (ghd[i] == gtl[i]) begin
                  chk("gnt_unexpected", i, int'(gnt_w[i]), 0);
               end else begin
                  chk("gnt", i, int'(gnt_w[i]), int'(eg[i][ghd[i] % 8]));
                  ghd[i]++;
               end
               chk("tx_at_gnt", i, int'(tx_w[i]), 1);
               chk("busy_at_gnt", i, int'(busy_w[i]), 1);
               act[i] = 1'b1;
            end else if (act[i]) begin
               if (be_last) begin
                  if (ehd[i] == etl[i]) begin
                     fail_now("sb_underflow", i);
                  end else begin
                     e = eb[i][ehd[i] % 64];
                     ehd[i]++;
                     if (e == 2) begin
                        chk("frame_done", i, int'(done_w[i]), 1);
                        chk("tx_after_done", i, int'(tx_w[i]), 1);
                        chk("busy_at_done", i, int'(busy_w[i]), 0);
                        act[i] = 1'b0;
                     end else begin
                        chk("tx_bit", i, int'(tx_w[i]), e);
                        chk("done_early", i, int'(done_w[i]), 0);
                        chk("busy_in_frame", i, int'(busy_w[i]), 1);
                     end
                  end
               end else begin
                  chk("tx_hold", i, int'(tx_w[i]), int'(last_tx[i]));
                  chk("done_no_strobe", i, int'(done_w[i]), 0);
               end
            end else begin
               chk("idle_tx", i, int'(tx_w[i]), 1);
               chk("idle_busy", i, int'(busy_w[i]), 0);
               chk("idle_done", i, int'(done_w[i]), 0);
            end
            last_tx[i] = tx_w[i];
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int  i;
      int  n;
      bit  got;
      bit  chg_done;
      i = v.inst;
      irr = v.irr;
      push_gnt(i, v.gnt);
      push_frame(i, (v.gnt == 2'b10) ? v.d1 : v.d0, v.par);
      @(posedge clk);
      #2;
      if (v.sync) begin
         for (int c = 0; c < 20 && !bit_en; c++) begin
            @(posedge clk);
            #2;
         end
      end
      d0_a[i] = v.d0;
      d1_a[i] = v.d1;
      par_a[i] = v.par;
      req_a[i] = v.req;
      wait_gnt(i, got);
      @(posedge clk);
      #2 req_a[i] = 2'b00;
      if (!got) return;
      n = 0;
      got = 1'b0;
      chg_done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (be_last) n++;
         if (v.chg && n == 3 && !chg_done) begin
            par_a[i] = 2'b10;
            d0_a[i] = 8'hFF;
            chg_done = 1'b1;
         end
         if (done_w[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now("done_timeout", i);
      else chk("frame_len", i, n - 1, v.len);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       tbl [8];
      bit         got;
      int         n;
      logic [1:0] g;

      for (int i = 0; i < 2; i++) begin
         req_a[i] = 2'b00;
         d0_a[i] = 8'h00;
         d1_a[i] = 8'h00;
         par_a[i] = 2'b00;
      end

      //          inst req    d0     d1     par    gnt    len chg irr sync
      tbl[0] = '{0, 2'b01, 8'hA5, 8'h00, 2'b01, 2'b01, 11, 0, 0, 0};
      tbl[1] = '{0, 2'b01, 8'h07, 8'h00, 2'b10, 2'b01, 11, 0, 0, 0};
      tbl[2] = '{0, 2'b10, 8'h00, 8'h07, 2'b00, 2'b10, 10, 0, 0, 0};
      tbl[3] = '{0, 2'b10, 8'h00, 8'h07, 2'b11, 2'b10, 10, 0, 0, 0};
      tbl[4] = '{0, 2'b01, 8'h3C, 8'h00, 2'b01, 2'b01, 11, 1, 0, 0};
      tbl[5] = '{1, 2'b01, 8'hC3, 8'h00, 2'b01, 2'b01, 12, 0, 1, 1};
      tbl[6] = '{1, 2'b10, 8'h00, 8'h5A, 2'b00, 2'b10, 11, 0, 1, 1};
      tbl[7] = '{0, 2'b11, 8'h44, 8'h81, 2'b10, 2'b10, 11, 0, 0, 0};

      // Reset state while reset is held.
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_tx", i, int'(tx_w[i]), 1);
         chk("rst_busy", i, int'(busy_w[i]), 0);
         chk("rst_gnt", i, int'(gnt_w[i]), 0);
         chk("rst_done", i, int'(done_w[i]), 0);
      end
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);

      for (int t = 0; t < 8; t++) run_vec(tbl[t]);

      // Mid-frame reset: requester 0 wins (pointer then favours 1), reset at DATA cnt=3.
      irr = 1'b0;
      push_gnt(0, 2'b01);
      push_frame(0, 8'h96, 2'b01);
      @(posedge clk);
      #2;
      d0_a[0] = 8'h96;
      par_a[0] = 2'b01;
      req_a[0] = 2'b01;
      wait_gnt(0, got);
      @(posedge clk);
      #2 req_a[0] = 2'b00;
      n = 0;
      for (int c = 0; c < 100 && n < 5; c++) begin
         @(negedge clk);
         if (be_last) n++;
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_tx", 0, int'(tx_w[0]), 1);
      chk("arst_busy", 0, int'(busy_w[0]), 0);
      chk("arst_gnt", 0, int'(gnt_w[0]), 0);
      chk("arst_done", 0, int'(done_w[0]), 0);
      clear_sb();
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);

      // Arbitration: both held, each drops for one cycle after its own grant.
      d0_a[0] = 8'hE1;
      d1_a[0] = 8'h1E;
      par_a[0] = 2'b01;
      for (int k = 0; k < 4; k++) begin
         push_gnt(0, (k % 2 == 0) ? 2'b01 : 2'b10);
         push_frame(0, (k % 2 == 0) ? 8'hE1 : 8'h1E, 2'b01);
      end
      @(posedge clk);
      #2 req_a[0] = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(0, got);
         if (!got) break;
         g = gnt_w[0];
         @(posedge clk);
         #2;
         if (k == 3) req_a[0] = 2'b00;
         else req_a[0] = req_a[0] & ~g;
         @(posedge clk);
         #2;
         if (k != 3) req_a[0] = 2'b11;
         wait_done(0);
      end
      req_a[0] = 2'b00;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("sb_bits_left", i, etl[i] - ehd[i], 0);
         chk("sb_gnts_left", i, gtl[i] - ghd[i], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
